// File: rtl/mem_port_arbiter.sv
// Byte-serial RAM port arbiter shared by instruction fetch (IF) and load/store (LS).
// One request is granted at a time. Reads account for the RAM's one-cycle read
// latency, and stores to the IO addresses wait while io_full is high.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter logic [31:0] IO_ADDR0     = 32'h0003_0000,
    parameter logic [31:0] IO_ADDR1     = 32'h0003_0004
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        io_full,
    input  logic        clear,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [1:0]  ls_len,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
    output logic [1:0]  busy,
    input  logic [7:0]  mem_din,
    output logic        mem_wr,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

    state_t        r_state, w_state_d;
    logic [2:0]    r_cnt, w_cnt_d;
    logic          r_gap, w_gap_d;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_addr;
    logic [1:0]    r_last;      // byte count minus one
    logic [31:0]   r_wdata;
    logic [31:0]   r_rbuf;
    logic          r_if_done, r_ls_done;
    logic [31:0]   r_if_data, r_ls_rdata;

    logic          w_io, w_block, w_force_if, w_gnt_ls, w_gnt_if;
    logic          w_rd_end, w_wr_last, w_rd_fin, w_wr_fin;
    logic [1:0]    w_idx;
    logic [31:0]   w_rbuf_d, w_wshift;

    assign w_io       = (r_addr == IO_ADDR0) || (r_addr == IO_ADDR1);
    // A done pulse still on the outputs means the requester has not yet dropped req.
    assign w_block    = !rdy_in || clear || r_if_done || r_ls_done;
    assign w_force_if = if_req && (r_starve == SW'(STARVE_LIMIT));
    assign w_gnt_ls   = (r_state == IDLE) && !w_block && ls_req && !w_force_if;
    assign w_gnt_if   = (r_state == IDLE) && !w_block && if_req && !w_gnt_ls;
    assign w_rd_end   = (r_cnt == ({1'b0, r_last} + 3'd1));
    assign w_wr_last  = (r_cnt == {1'b0, r_last});
    // Byte arriving on mem_din belongs to the address issued one cycle earlier.
    assign w_idx      = r_cnt[1:0] - 2'd1;
    assign w_rbuf_d   = r_rbuf | ({24'b0, mem_din} << {w_idx, 3'b000});
    assign w_wshift   = r_wdata >> {r_cnt[1:0], 3'b000};

    assign busy     = {r_state == IF_RD, (r_state == LS_RD) || (r_state == LS_WR)};
    assign if_done  = r_if_done;
    assign ls_done  = r_ls_done;
    assign if_data  = r_if_data;
    assign ls_rdata = r_ls_rdata;

    // Next-state, byte counter and RAM pin decode.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_gap_d   = r_gap;
        w_rd_fin  = 1'b0;
        w_wr_fin  = 1'b0;
        mem_wr    = 1'b0;
        mem_a     = 32'h0;
        mem_dout  = 8'h0;
        unique case (r_state)
            IDLE: begin
                if (w_gnt_ls) begin
                    w_state_d = ls_we ? LS_WR : LS_RD;
                    w_cnt_d   = 3'd0;
                    w_gap_d   = 1'b0;
                end else if (w_gnt_if) begin
                    w_state_d = IF_RD;
                    w_cnt_d   = 3'd0;
                    w_gap_d   = 1'b0;
                end
            end
            IF_RD, LS_RD: begin
                mem_a = r_addr + 32'(r_cnt);
                if (clear) begin
                    w_state_d = IDLE;
                    w_cnt_d   = 3'd0;
                end else if (w_rd_end) begin
                    w_rd_fin  = 1'b1;
                    w_state_d = IDLE;
                    w_cnt_d   = 3'd0;
                end else begin
                    w_cnt_d = r_cnt + 3'd1;
                end
            end
            LS_WR: begin
                if (w_io && (r_gap || io_full)) begin
                    // IO stall or mandatory gap: pins idle, counter held.
                    w_gap_d = 1'b0;
                end else begin
                    mem_wr   = 1'b1;
                    mem_a    = r_addr + 32'(r_cnt);
                    mem_dout = w_wshift[7:0];
                    if (w_wr_last) begin
                        w_wr_fin  = 1'b1;
                        w_state_d = IDLE;
                        w_cnt_d   = 3'd0;
                    end else begin
                        w_cnt_d = r_cnt + 3'd1;
                        w_gap_d = w_io;
                    end
                end
            end
            default: w_state_d = IDLE;
        endcase
        if (!rdy_in) begin
            w_state_d = r_state;
            w_cnt_d   = r_cnt;
            w_gap_d   = r_gap;
            w_rd_fin  = 1'b0;
            w_wr_fin  = 1'b0;
            mem_wr    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_gap   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_gap   <= w_gap_d;
        end
    end

    // Request latching, read assembly, done pulses and starvation counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_addr     <= 32'h0;
            r_last     <= 2'd0;
            r_wdata    <= 32'h0;
            r_rbuf     <= 32'h0;
            r_if_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_if_data  <= 32'h0;
            r_ls_rdata <= 32'h0;
            r_starve   <= '0;
        end else begin
            r_if_done <= 1'b0;
            r_ls_done <= 1'b0;
            if (rdy_in) begin
                if (w_gnt_ls) begin
                    r_addr  <= ls_addr;
                    r_last  <= ls_len;
                    r_wdata <= ls_wdata;
                    r_rbuf  <= 32'h0;
                end else if (w_gnt_if) begin
                    r_addr <= if_addr;
                    r_last <= 2'd3;
                    r_rbuf <= 32'h0;
                end else if ((r_state == IF_RD || r_state == LS_RD) && !clear &&
                             r_cnt != 3'd0) begin
                    r_rbuf <= w_rbuf_d;
                end
                if (w_rd_fin) begin
                    if (r_state == IF_RD) begin
                        r_if_done <= 1'b1;
                        r_if_data <= w_rbuf_d;
                    end else begin
                        r_ls_done  <= 1'b1;
                        r_ls_rdata <= w_rbuf_d;
                    end
                end
                if (w_wr_fin) begin
                    r_ls_done <= 1'b1;
                end
                if (!if_req || w_gnt_if) begin
                    r_starve <= '0;
                end else if (w_gnt_ls && r_starve != SW'(STARVE_LIMIT)) begin
                    r_starve <= r_starve + SW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random ops,
// checked against a byte-array RAM model and per-op latency/write-list rules.
module tb_mem_port_arbiter;

    localparam logic [31:0] IO0 = 32'h0003_0000;
    localparam logic [31:0] IO1 = 32'h0003_0004;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, io_full, clear;
    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [1:0]  ls_len;
    logic        if_done, ls_done, mem_wr;
    logic [31:0] if_data, ls_rdata, mem_a;
    logic [1:0]  busy;
    logic [7:0]  mem_din, mem_dout;

    logic [7:0]  ram [0:255];
    logic [39:0] wr_log [0:1023];
    int          wr_n = 0;
    int          n_viol = 0;
    bit          prev_io_wr = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    mem_port_arbiter dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .io_full  (io_full),
        .clear    (clear),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_data  (if_data),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_len   (ls_len),
        .ls_wdata (ls_wdata),
        .ls_done  (ls_done),
        .ls_rdata (ls_rdata),
        .busy     (busy),
        .mem_din  (mem_din),
        .mem_wr   (mem_wr),
        .mem_a    (mem_a),
        .mem_dout (mem_dout)
    );

    always #5 clk_in = ~clk_in;

    function automatic bit is_io(input logic [31:0] a);
        return (a >= IO0) && (a <= IO1 + 32'd3);
    endfunction

    // RAM: one-cycle read latency, indexed by the low address byte.
    always @(posedge clk_in) begin
        cyc     <= cyc + 1;
        mem_din <= ram[mem_a[7:0]];
    end

    // Write logger and pin-rule monitor, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (mem_wr) begin
            wr_log[wr_n % 1024] <= {mem_a, mem_dout};
            wr_n <= wr_n + 1;
        end
        if (mem_wr && (!rdy_in || (is_io(mem_a) && (io_full || prev_io_wr))))
            n_viol <= n_viol + 1;
        prev_io_wr <= mem_wr && is_io(mem_a);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] ai;
            ai = a + 32'(i);
            r[8*i +: 8] = ram[ai[7:0]];
        end
        return r;
    endfunction

    // sel: 0 if_done, 1 ls_done, 2 busy[1], 3 busy!=0
    task automatic wait_for(input int sel, input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            @(posedge clk_in); #1;
            ok = (sel == 0) ? if_done : (sel == 1) ? ls_done : (sel == 2) ? busy[1] : (busy != 2'b00);
        end
    endtask

    task automatic do_op(input string tag, input bit is_if, input bit we, input logic [31:0] a,
                         input logic [1:0] len, input logic [31:0] wd, input int stall_at,
                         input int io_hold, input bit io_rand);
        int  n, w0, t_g, lat;
        bit  ok, io_st;
        n     = is_if ? 4 : int'(len) + 1;
        io_st = !is_if && we && (a == IO0 || a == IO1);
        w0    = wr_n;
        io_full = (io_hold > 0);
        if (is_if) begin
            if_req = 1'b1; if_addr = a;
        end else begin
            ls_req = 1'b1; ls_we = we; ls_addr = a; ls_len = len; ls_wdata = wd;
        end
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(posedge clk_in); #1;
            ok = is_if ? busy[1] : busy[0];
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        check({tag, " grant"}, 64'(ok), 64'd1);
        if (!ok) begin
            io_full = 1'b0;
            return;
        end
        t_g = cyc;
        ok  = 1'b0;
        for (int j = 1; j < 60 && !ok; j++) begin
            @(posedge clk_in); #1;
            ok = is_if ? if_done : ls_done;
            if (io_rand) io_full = 1'($urandom_range(0, 1));
            else         io_full = (j < io_hold);
            if (stall_at >= 0) rdy_in = !(j >= stall_at && j < stall_at + 2);
        end
        io_full = 1'b0;
        rdy_in  = 1'b1;
        check({tag, " done"}, 64'(ok), 64'd1);
        if (!ok) return;
        lat = cyc - t_g;
        if (is_if || !we) begin
            check({tag, " data"}, 64'(is_if ? if_data : ls_rdata), 64'(model_read(a, n)));
            if (stall_at < 0) check({tag, " latency"}, 64'(lat), 64'(n + 1));
        end else begin
            check({tag, " write count"}, 64'(wr_n - w0), 64'(n));
            for (int i = 0; i < n; i++) begin
                logic [31:0] ai;
                ai = a + 32'(i);
                check({tag, " write"}, 64'(wr_log[(w0 + i) % 1024]), 64'({ai, wd[8*i +: 8]}));
            end
            if (stall_at < 0 && !io_st) check({tag, " latency"}, 64'(lat), 64'(n));
            if (stall_at < 0 && io_st && !io_rand)
                check({tag, " io latency"}, 64'(lat), 64'(io_hold + 2 * n - 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok, seen, got_if, pb;
        int          w0, n_ls, kind, stall;
        logic [31:0] a, wd, wdv;

        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
        rst_in = 1'b1; rdy_in = 1'b1; io_full = 1'b0; clear = 1'b0;
        if_req = 1'b0; if_addr = 32'h0; ls_req = 1'b0; ls_we = 1'b0;
        ls_addr = 32'h0; ls_len = 2'd0; ls_wdata = 32'h0;
        repeat (3) @(posedge clk_in);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'({if_done, ls_done}), 64'd0);
        check("reset data", 64'({if_data, ls_rdata}), 64'd0);
        check("reset pins", 64'({mem_wr, mem_a, mem_dout}), 64'd0);
        rst_in = 1'b0;

        // IF word fetch, LS halfword load
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h00; ram[3] = 8'h00;
        do_op("if 1000", 1'b1, 1'b0, 32'h1000, 2'd0, 32'h0, -1, 0, 1'b0);
        check("if 1000 word", 64'(if_data), 64'h0000_0513);
        ram[2] = 8'h34; ram[3] = 8'h12;
        do_op("ls half", 1'b0, 1'b0, 32'h2002, 2'd1, 32'h0, -1, 0, 1'b0);
        check("ls half word", 64'(ls_rdata), 64'h0000_1234);

        // Simultaneous requests: LS store first, then IF
        w0 = wr_n; wdv = 32'hDEAD_BEEF;
        if_addr = 32'h1000; if_req = 1'b1;
        ls_we = 1'b1; ls_addr = 32'h100; ls_len = 2'd3; ls_wdata = wdv; ls_req = 1'b1;
        wait_for(3, 20, ok);
        check("both grant", 64'(ok), 64'd1);
        check("both ls first", 64'(busy), 64'd1);
        ls_req = 1'b0;
        wait_for(1, 20, ok);
        check("both ls done", 64'(ok), 64'd1);
        check("both write count", 64'(wr_n - w0), 64'd4);
        for (int i = 0; i < 4; i++)
            check("both write", 64'(wr_log[(w0 + i) % 1024]), 64'({32'h100 + 32'(i), wdv[8*i +: 8]}));
        wait_for(2, 20, ok);
        check("both if granted", 64'(ok), 64'd1);
        if_req = 1'b0;
        wait_for(0, 20, ok);
        check("both if done", 64'(ok), 64'd1);
        check("both if data", 64'(if_data), 64'(model_read(32'h1000, 4)));

        // IO stores
        do_op("io byte", 1'b0, 1'b1, IO0, 2'd0, 32'h41, -1, 3, 1'b0);
        do_op("io word", 1'b0, 1'b1, IO1, 2'd3, 32'h1122_3344, -1, 0, 1'b0);
        do_op("io rand", 1'b0, 1'b1, IO0, 2'd2, $urandom, -1, 0, 1'b1);

        // Starvation: IF forced in after STARVE_LIMIT LS grants
        ls_we = 1'b0; ls_len = 2'd0; ls_addr = 32'h40; if_addr = 32'h80;
        ls_req = 1'b1; if_req = 1'b1;
        n_ls = 0; got_if = 1'b0; pb = 1'b0;
        for (int k = 0; k < 200 && !got_if; k++) begin
            @(posedge clk_in); #1;
            if (busy[1]) got_if = 1'b1;
            else if (busy[0] && !pb) n_ls++;
            pb = busy[0];
        end
        ls_req = 1'b0; if_req = 1'b0;
        check("starve if granted", 64'(got_if), 64'd1);
        check("starve ls count", 64'(n_ls), 64'd4);
        wait_for(0, 20, ok);
        check("starve if done", 64'(ok), 64'd1);
        check("starve if data", 64'(if_data), 64'(model_read(32'h80, 4)));

        // Clear at cnt=2 of an IF read
        if_addr = 32'h200; if_req = 1'b1;
        wait_for(2, 20, ok);
        if_req = 1'b0;
        check("clear grant", 64'(ok), 64'd1);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        clear = 1'b1;
        @(posedge clk_in); #1;
        clear = 1'b0;
        check("clear busy", 64'(busy), 64'd0);
        seen = if_done;
        repeat (8) begin
            @(posedge clk_in); #1;
            if (if_done) seen = 1'b1;
        end
        check("clear no done", 64'(seen), 64'd0);
        // Clear in IDLE suppresses that cycle's grant
        ls_we = 1'b0; ls_len = 2'd0; ls_addr = 32'h10; ls_req = 1'b1; clear = 1'b1;
        @(posedge clk_in); #1;
        check("clear blocks grant", 64'(busy), 64'd0);
        clear = 1'b0; ls_req = 1'b0;
        do_op("after clear", 1'b0, 1'b0, 32'h10, 2'd3, 32'h0, -1, 0, 1'b0);

        // rdy_in low for two cycles mid-store
        do_op("rdy stall", 1'b0, 1'b1, 32'h180, 2'd3, 32'hCAFE_F00D, 2, 0, 1'b0);

        // Address wrap
        do_op("wrap if", 1'b1, 1'b0, 32'hFFFF_FFFE, 2'd0, 32'h0, -1, 0, 1'b0);
        do_op("wrap st", 1'b0, 1'b1, 32'hFFFF_FFFF, 2'd1, 32'hA5C3, -1, 0, 1'b0);

        // Reset mid-store aborts the op and clears outputs
        w0 = wr_n;
        ls_we = 1'b1; ls_addr = 32'h300; ls_len = 2'd3; ls_wdata = 32'h0102_0304; ls_req = 1'b1;
        wait_for(3, 20, ok);
        ls_req = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        check("reset abort busy", 64'(busy), 64'd0);
        check("reset abort writes", 64'(wr_n - w0), 64'd2);
        check("reset abort data", 64'({if_data, ls_rdata}), 64'd0);
        seen = ls_done;
        repeat (6) begin
            @(posedge clk_in); #1;
            if (ls_done) seen = 1'b1;
        end
        check("reset abort no done", 64'(seen), 64'd0);

        // Random operations
        for (int r = 0; r < 40; r++) begin
            kind  = int'($urandom_range(0, 2));
            a     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                                : 32'($urandom_range(0, 32'h1FFFF));
            wd    = $urandom;
            stall = (kind == 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : -1;
            do_op($sformatf("rnd%0d", r), kind == 0, kind == 2, a, 2'($urandom_range(0, 3)), wd,
                  stall, 0, (kind != 0) && ($urandom_range(0, 1) == 1));
        end

        check("pin rule violations", 64'(n_viol), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
